irda_tx_sequencer: RTL and testbench
====================================

// Module: irda_tx_sequencer
// PURPOSE
//  Transmit-side controller for the IrDA SIR link: one parallel byte in, one IR-encoded UART frame out.
//  Frame is start(0), 8 data bits LSB first, stop(1).
//  Owns the bit-period timer that paces the frame: BIT_PERIOD clocks per slot, 5208 clocks at the 9600-baud setting.
//  A 0 slot emits one IR pulse of PULSE_WIDTH clocks at slot start; a 1 slot emits no pulse.
//  Sits between the UART host interface and the IR LED driver.
// PARAMETERS
//  BIT_PERIOD   5208  clocks per bit slot (timer counts 0..BIT_PERIOD-1); legal range 4..8191
//  PULSE_WIDTH  977   IR pulse length in clocks (~3/16 slot); 1 <= PULSE_WIDTH < BIT_PERIOD
//  CNT_W        13    slot-timer width; must hold BIT_PERIOD-1
// PORTS
//  clock     in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high reset
//  tx_start  in   1  request to send tx_data; sampled only in IDLE
//  tx_data   in   8  byte to send; captured on the accepting edge
//  tx_abort  in   1  synchronous abort of the frame in progress
//  tx_busy   out  1  high from the accepting edge until the frame ends or is aborted
//  tx_done   out  1  one-cycle pulse after the last stop-bit clock
//  bit_tick  out  1  one-cycle pulse on each slot's last clock (timer == BIT_PERIOD-1)
//  ir_out    out  1  IR LED drive, active high, registered
// BEHAVIOUR
//  Reset (async, any state):
//   - FSM to IDLE; timer, bit index and shift register to 0.
//   - tx_busy, tx_done, bit_tick and ir_out all 0.
//  States and transitions:
//   - IDLE: tx_start=1 & tx_abort=0 at an edge -> START; tx_data latched; timer=0; tx_busy=1.
//   - START -> DATA when timer == BIT_PERIOD-1.
//   - DATA: bit index 0..7; advance at each timer == BIT_PERIOD-1; after index 7 -> STOP.
//   - STOP -> IDLE at timer == BIT_PERIOD-1; tx_done=1 for exactly the next cycle; tx_busy=0.
//  Timer:
//   - Increments every clock outside IDLE; wraps BIT_PERIOD-1 -> 0 at each slot boundary.
//   - Never exceeds BIT_PERIOD-1.
//  Slot timing:
//   - Accepting edge = cycle 0; slot k occupies cycles k*BIT_PERIOD .. (k+1)*BIT_PERIOD-1, k = 0..9.
//   - Whole frame is exactly 10*BIT_PERIOD cycles; tx_done is high in cycle 10*BIT_PERIOD.
//  ir_out:
//   - 1 during cycles 0..PULSE_WIDTH-1 of every slot whose bit is 0; else 0.
//   - Start slot always pulses; stop slot never pulses; always 0 in IDLE.
//  Handshake:
//   - tx_start is ignored while tx_busy=1.
//   - tx_data may change freely after the accepting edge.
//   - A new tx_start in the tx_done cycle is accepted (back-to-back frames, no gap slot).
//  tx_abort (any non-IDLE state):
//   - Next edge -> IDLE; ir_out=0 immediately at that edge, truncating a pulse in progress.
//   - tx_busy=0; no tx_done.
//  tx_abort in IDLE:
//   - Blocks tx_start on the same edge (abort wins); otherwise no effect.
//  bit_tick:
//   - Registered; asserts in the same cycle the timer reads BIT_PERIOD-1, 10 times per frame.
// TESTING (bench uses BIT_PERIOD=16, PULSE_WIDTH=3)
//  1. Reset:
//     - Assert reset mid-frame with ir_out=1 -> all outputs 0 asynchronously; FSM in IDLE.
//     - Release reset -> no activity without tx_start.
//  2. Send 0x55:
//     - ir_out high at cycles 0-2, 32-34, 64-66, 96-98, 128-130 only.
//     - tx_done high at cycle 160; tx_busy high over cycles 0-159.
//  3. Send 0xFF -> only the start pulse (cycles 0-2). Send 0x00 -> 9 pulses at 16k, k = 0..8.
//     No pulse in slot 9 in either case.
//  4. Back-to-back:
//     - Hold tx_start=1 sending 0xA5 then 0x3C -> second frame accepted in the tx_done cycle.
//     - Second start pulse at cycles 160-162; tx_data change at cycle 5 does not alter frame 1.
//  5. Abort:
//     - tx_abort at cycle 33 (inside a pulse) -> ir_out=0 and tx_busy=0 from cycle 34.
//     - No tx_done; a new tx_start at cycle 40 starts a clean frame.
//  6. Simultaneous tx_start+tx_abort in IDLE -> not accepted, tx_busy stays 0.
//     Also: tx_start while busy -> ignored; bit_tick count = 10 per frame.

Source files
------------

// File: rtl/irda_tx_sequencer_if.sv
// Host-side bundle of the IrDA SIR transmit sequencer.
//   tx_start/tx_data/tx_abort : host request, byte and abort
//   tx_busy/tx_done/bit_tick  : sequencer status
//   ir_out                    : IR LED drive (active high)
// master = UART host side, slave = sequencer side.
interface irda_tx_sequencer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_abort;
    logic       tx_busy;
    logic       tx_done;
    logic       bit_tick;
    logic       ir_out;

    modport master (
        output tx_start, tx_data, tx_abort,
        input  tx_busy, tx_done, bit_tick, ir_out
    );

    modport slave (
        input  tx_start, tx_data, tx_abort,
        output tx_busy, tx_done, bit_tick, ir_out
    );
endinterface

// File: rtl/irda_tx_sequencer.sv
// IrDA SIR transmit sequencer: takes one byte and sends a start(0), 8 data
// bits LSB first and stop(1) frame, one BIT_PERIOD-clock slot per bit.
// Every 0 slot carries a PULSE_WIDTH-clock IR pulse at slot start.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : irda_tx_sequencer_if.slave (request, status and ir_out)
// All outputs are registered; they are computed from next-state values so
// that frame cycle 0 (the cycle after the accepting edge) already shows the
// start pulse, tx_busy and timer == 0.
module irda_tx_sequencer #(
    parameter int unsigned BIT_PERIOD  = 5208,
    parameter int unsigned PULSE_WIDTH = 977,
    parameter int unsigned CNT_W       = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    irda_tx_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n, timer_step;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             tick, tick_n;
    logic             ir, ir_n;
    logic             slot_end;
    logic             accept;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tick    <= 1'b0;
            ir      <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            busy    <= busy_n;
            done    <= done_n;
            tick    <= tick_n;
            ir      <= ir_n;
        end
    end

    // Next-state, timer and registered-output logic.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        busy_n     = busy;
        done_n     = 1'b0;
        tick_n     = 1'b0;
        ir_n       = 1'b0;
        slot_end   = (timer == LAST_TICK);
        accept     = bus.tx_start && !bus.tx_abort;
        timer_step = slot_end ? '0 : timer + CNT_W'(1);

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    shreg_n   = bus.tx_data;
                    timer_n   = '0;
                    bit_idx_n = '0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                timer_n = timer_step;
                if (slot_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                timer_n = timer_step;
                if (slot_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                timer_n = timer_step;
                if (slot_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    // The frame-ending edge also accepts a new request so
                    // back-to-back frames run with no gap slot.
                    if (accept) begin
                        state_n   = START;
                        shreg_n   = bus.tx_data;
                        bit_idx_n = '0;
                        busy_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Abort overrides everything outside IDLE, including a pending done.
        if (state != IDLE && bus.tx_abort) begin
            state_n   = IDLE;
            timer_n   = '0;
            bit_idx_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b0;
        end

        tick_n = (state_n != IDLE) && (timer_n == LAST_TICK);
        ir_n   = ((state_n == START) || (state_n == DATA && !shreg_n[bit_idx_n]))
                 && (timer_n < PULSE_END);
    end

    assign bus.tx_busy  = busy;
    assign bus.tx_done  = done;
    assign bus.bit_tick = tick;
    assign bus.ir_out   = ir;

endmodule

// File: tb/tb_irda_tx_sequencer.sv
// Self-checking bench for irda_tx_sequencer with BIT_PERIOD=16, PULSE_WIDTH=3.
// Expected per-cycle outputs {ir_out, tx_busy, tx_done, bit_tick} are pushed
// into a queue when a frame is launched and compared as the DUT produces them.
module tb_irda_tx_sequencer;

    localparam int BP    = 16;
    localparam int PW    = 3;
    localparam int FRAME = 10 * BP;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   edge_n = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    int   pulse_cnt = 0;
    logic ir_prev = 1'b0;
    exp_t exp_q[$];

    irda_tx_sequencer_if bus();

    irda_tx_sequencer #(
        .BIT_PERIOD (BP),
        .PULSE_WIDTH(PW),
        .CNT_W      (13)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.ir_out, bus.tx_busy, bus.tx_done, bus.bit_tick};
    endfunction

    // Reference waveform of one frame cycle, straight from the slot definition.
    function automatic logic [3:0] frame_val(input logic [7:0] b, input int c);
        int   slot;
        int   t;
        logic bitv;
        slot = c / BP;
        t    = c % BP;
        if (slot == 0)      bitv = 1'b0;
        else if (slot == 9) bitv = 1'b1;
        else                bitv = b[3'(slot - 1)];
        return {(!bitv && t < PW), 1'b1, 1'b0, (t == BP - 1)};
    endfunction

    task automatic push_frame(input int a, input logic [7:0] b, input bit done_first, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.cyc = a + c;
            e.v   = frame_val(b, c);
            if (c == 0 && done_first) e.v[1] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int a, input int n, input bit done_first);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.cyc = a + c;
            e.v   = {2'b00, (c == 0 && done_first), 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int n);
        while (edge_n < n) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.bit_tick) tick_cnt++;
                if (bus.ir_out && !ir_prev) pulse_cnt++;
                ir_prev = bus.ir_out;
                while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                    e = exp_q.pop_front();
                    check("sb_skip", 32'(edge_n), 32'(e.cyc));
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                    e = exp_q.pop_front();
                    check($sformatf("out@%0d", edge_n), 32'(outs()), 32'(e.v));
                end
            end
        end
    endtask

    // Launch one frame, check its waveform, tick count and pulse count.
    task automatic run_frame(input logic [7:0] b, input int pulses);
        int a, t0, p0;
        t0 = tick_cnt;
        p0 = pulse_cnt;
        a  = edge_n + 1;
        push_frame(a, b, 1'b0, FRAME);
        push_idle(a + FRAME, 1, 1'b1);
        push_idle(a + FRAME + 1, 3, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_data  = b;
        @(negedge clock);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
        wait_drain(400);
        check($sformatf("ticks_%02h", b), 32'(tick_cnt - t0), 32'd10);
        check($sformatf("pulses_%02h", b), 32'(pulse_cnt - p0), 32'(pulses));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, t0, p0;
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_abort = 1'b0;
        fork
            monitor();
        join_none

        // Reset state and quiet idle after release.
        repeat (3) @(negedge clock);
        check("rst_out", 32'(outs()), 32'd0);
        reset = 1'b0;
        push_idle(edge_n + 1, 8, 1'b0);
        wait_drain(50);

        // Basic frames.
        run_frame(8'h55, 5);
        run_frame(8'hFF, 1);
        run_frame(8'h00, 9);

        // Back-to-back with tx_start held, tx_data changed mid frame 1.
        t0 = tick_cnt;
        p0 = pulse_cnt;
        a  = edge_n + 1;
        push_frame(a, 8'hA5, 1'b0, FRAME);
        push_frame(a + FRAME, 8'h3C, 1'b1, FRAME);
        push_idle(a + 2 * FRAME, 1, 1'b1);
        push_idle(a + 2 * FRAME + 1, 2, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hA5;
        wait_until(a + 5);
        bus.tx_data = 8'h3C;
        wait_until(a + FRAME);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
        wait_drain(500);
        check("b2b_ticks", 32'(tick_cnt - t0), 32'd20);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd10);

        // Abort inside the slot-2 pulse, then a clean frame from cycle 40.
        t0 = tick_cnt;
        a  = edge_n + 1;
        push_frame(a, 8'h55, 1'b0, 34);
        push_idle(a + 34, 7, 1'b0);
        push_frame(a + 41, 8'h96, 1'b0, FRAME);
        push_idle(a + 41 + FRAME, 1, 1'b1);
        push_idle(a + 42 + FRAME, 2, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        @(negedge clock);
        bus.tx_start = 1'b0;
        wait_until(a + 33);
        bus.tx_abort = 1'b1;
        @(negedge clock);
        bus.tx_abort = 1'b0;
        wait_until(a + 40);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h96;
        @(negedge clock);
        bus.tx_start = 1'b0;
        wait_drain(400);
        check("abort_ticks", 32'(tick_cnt - t0), 32'd12);

        // Start and abort together in IDLE: not accepted.
        push_idle(edge_n + 1, 5, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_abort = 1'b1;
        @(negedge clock);
        bus.tx_start = 1'b0;
        bus.tx_abort = 1'b0;
        wait_drain(20);

        // tx_start while busy is ignored.
        t0 = tick_cnt;
        a  = edge_n + 1;
        push_frame(a, 8'hC3, 1'b0, FRAME);
        push_idle(a + FRAME, 1, 1'b1);
        push_idle(a + FRAME + 1, 3, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hC3;
        @(negedge clock);
        bus.tx_start = 1'b0;
        wait_until(a + 50);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h00;
        @(negedge clock);
        bus.tx_start = 1'b0;
        wait_drain(400);
        check("busy_ticks", 32'(tick_cnt - t0), 32'd10);

        // Asynchronous reset mid-pulse, then no activity after release.
        a = edge_n + 1;
        push_frame(a, 8'h55, 1'b0, 34);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        @(negedge clock);
        bus.tx_start = 1'b0;
        wait_until(a + 33);
        #2;
        check("pre_rst_ir", 32'(bus.ir_out), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async", 32'(outs()), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        push_idle(edge_n + 1, 10, 1'b0);
        wait_drain(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
